// File: rtl/vadd_checker.sv
// vadd_checker: snoops operand pairs, queues the lane-wise golden sum and
// checks each datapath result in order; reports pass/fail and protocol errors.
module vadd_checker #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LANES    = 4,
  parameter int unsigned NUM_VECS = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [LANES*WIDTH-1:0]        in_a,
  input  logic [LANES*WIDTH-1:0]        in_b,
  input  logic                          res_valid,
  input  logic [LANES*WIDTH-1:0]        res_y,
  output logic                          fail,
  output logic                          finish,
  output logic [2:0]                    fail_code,
  output logic [LANES-1:0]              err_lanes,
  output logic [$clog2(NUM_VECS+1)-1:0] done_count
);

  localparam int unsigned VW     = LANES * WIDTH;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned DC_W   = $clog2(NUM_VECS + 1);

  localparam logic [2:0] CODE_MISMATCH  = 3'd1;
  localparam logic [2:0] CODE_UNDERFLOW = 3'd2;
  localparam logic [2:0] CODE_OVERFLOW  = 3'd3;
  localparam logic [2:0] CODE_TIMEOUT   = 3'd4;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PASS = 2'd1,
    S_FAIL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              fail_q, fail_d;
  logic              finish_q, finish_d;
  logic [2:0]        code_q, code_d;
  logic [LANES-1:0]  lanes_q, lanes_d;
  logic [DC_W-1:0]   done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [VW-1:0]     mem_q [DEPTH];

  logic [VW-1:0]     golden_c;
  logic [VW-1:0]     head_c;
  logic [LANES-1:0]  lane_diff_c;
  logic              empty_c, full_c, waiting_c;
  logic              underflow_c, mismatch_c, overflow_c, timeout_c;
  logic              push_c, pop_c;

  assign head_c = mem_q[rd_ptr_q];

  // Lane-wise golden sum (carry dropped per lane) and per-lane compare vs queue head.
  always_comb begin
    golden_c    = '0;
    lane_diff_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      golden_c[i*WIDTH +: WIDTH] = in_a[i*WIDTH +: WIDTH] + in_b[i*WIDTH +: WIDTH];
      lane_diff_c[i]             = head_c[i*WIDTH +: WIDTH] != res_y[i*WIDTH +: WIDTH];
    end
  end

  // Error detection from current occupancy and this cycle's handshakes.
  always_comb begin
    empty_c     = (cnt_q == '0);
    full_c      = (cnt_q == CNT_W'(DEPTH));
    waiting_c   = !empty_c && !res_valid;
    underflow_c = res_valid && empty_c;
    mismatch_c  = res_valid && !empty_c && (|lane_diff_c);
    overflow_c  = in_valid && !res_valid && full_c;
    timeout_c   = waiting_c && (wait_q == WAIT_W'(TIMEOUT - 1));
  end

  // Next-state: error priority, pass counting, FIFO bookkeeping and wait counter.
  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    finish_d = finish_q;
    code_d   = code_q;
    lanes_d  = lanes_q;
    done_d   = done_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    wait_d   = wait_q;
    push_c   = 1'b0;
    pop_c    = 1'b0;

    if (state_q == S_RUN) begin
      if (underflow_c) begin
        state_d = S_FAIL;
        fail_d  = 1'b1;
        code_d  = CODE_UNDERFLOW;
      end else if (mismatch_c) begin
        state_d = S_FAIL;
        fail_d  = 1'b1;
        code_d  = CODE_MISMATCH;
        lanes_d = lane_diff_c;
      end else if (overflow_c) begin
        state_d = S_FAIL;
        fail_d  = 1'b1;
        code_d  = CODE_OVERFLOW;
      end else if (timeout_c) begin
        state_d = S_FAIL;
        fail_d  = 1'b1;
        code_d  = CODE_TIMEOUT;
      end else begin
        push_c = in_valid;
        pop_c  = res_valid;
        if (res_valid) begin
          done_d = done_q + DC_W'(1);
          if (done_d == DC_W'(NUM_VECS)) begin
            state_d  = S_PASS;
            finish_d = 1'b1;
          end
        end
        if (waiting_c) begin
          if (wait_q != WAIT_W'(TIMEOUT)) begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else begin
          wait_d = '0;
        end
      end
    end

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // State and control registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_RUN;
      fail_q   <= 1'b0;
      finish_q <= 1'b0;
      code_q   <= '0;
      lanes_q  <= '0;
      done_q   <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      fail_q   <= fail_d;
      finish_q <= finish_d;
      code_q   <= code_d;
      lanes_q  <= lanes_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      wait_q   <= wait_d;
    end
  end

  // Expected-value storage; pointers alone define validity, so no reset needed.
  always_ff @(posedge clock) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= golden_c;
    end
  end

  assign fail       = fail_q;
  assign finish     = finish_q;
  assign fail_code  = code_q;
  assign err_lanes  = lanes_q;
  assign done_count = done_q;

endmodule

// File: doc/vadd_checker.md
# vadd_checker

Self-checking result monitor for the vector-add test harness. It sits between the vadd datapath and the top-level bench. It snoops each operand pair issued to the datapath, computes the golden lane-wise sum, and queues it. It then compares each datapath result against the queued value in order, and drives the sticky `fail`/`finish` pair that the bench polls to end simulation. It also reports protocol errors (underflow, overflow, timeout) so a hung or misaligned datapath never silently passes.

## Interface
Parameters:
- `WIDTH`, 8: bits per lane.
- `LANES`, 4: lanes per vector.
- `NUM_VECS`, 16: results to check before `finish`.
- `DEPTH`, 4: expected-value queue depth, power of two, ≥2.
- `TIMEOUT`, 1024: max cycles waiting for a result while the queue is non-empty.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low; low = in reset. This is already decided.
- `in_valid` in 1: operands issued to the datapath this cycle.
- `in_a` in LANES*WIDTH: operand A; lane i = bits [i*WIDTH +: WIDTH].
- `in_b` in LANES*WIDTH: operand B.
- `res_valid` in 1: datapath result valid this cycle.
- `res_y` in LANES*WIDTH: datapath result.
- `fail` out 1: sticky failure flag.
- `finish` out 1: sticky pass-complete flag.
- `fail_code` out 3: 0 none, 1 mismatch, 2 underflow, 3 overflow, 4 timeout.
- `err_lanes` out LANES: mismatching-lane mask of the failing compare.
- `done_count` out clog2(NUM_VECS+1): results compared and passed.

## Operation
- Golden computation: per lane `(a_i + b_i) mod 2^WIDTH`. Carry is discarded and never crosses lanes.
- Issue: on `in_valid`, push the golden vector into a FIFO with depth `DEPTH`.
- Result: on `res_valid`, pop the FIFO head and compare it with `res_y`. All lanes equal means the result passes and `done_count` increments.
- Simultaneous push and pop is legal at any occupancy, including full. Occupancy is unchanged.
- Simultaneous push and pop at empty is an underflow. A result can never be consumed in its own issue cycle.
- Error conditions, evaluated each active cycle in priority order underflow > mismatch > overflow > timeout:
  - Underflow: `res_valid` with occupancy 0.
  - Mismatch: any lane differs. `err_lanes` gets one bit per differing lane.
  - Overflow: `in_valid` without `res_valid` at occupancy `DEPTH`. The push is dropped.
  - Timeout: the wait counter reaches `TIMEOUT`.
- Wait counter:
  - Increments when occupancy > 0 and `res_valid`=0.
  - Clears on `res_valid` or when occupancy is 0.
  - Saturates.
- States: RUN, PASS, FAIL.
  - RUN→FAIL on any error; `fail_code`/`err_lanes` latch the highest-priority error.
  - RUN→PASS when the `NUM_VECS`-th passing compare occurs.
  - If the last compare mismatches, the next state is FAIL, not PASS.
- PASS and FAIL are terminal until reset. In those states all inputs are ignored and every output holds.
- `fail` and `finish` are never both 1.

## Timing
- Reset: while `reset`=0 at a rising edge, the next state is:
  - `fail`=0, `finish`=0, `fail_code`=0, `err_lanes`=0, `done_count`=0.
  - FIFO empty, wait counter 0, state RUN.
- Reset asserted mid-operation, including in PASS or FAIL, takes effect at the next edge and discards queued values.
- All outputs are registered.
- Compare-to-flag latency is 1 cycle. Given a `res_valid` cycle at edge k, `fail`/`finish`/`done_count` update at edge k+1.
- Overflow and underflow flag at the edge after the offending cycle.
- Timeout: `fail` rises at the edge after `TIMEOUT` consecutive waiting cycles.
- No backpressure is applied. The checker is a passive observer.

## Test plan
All scenarios use WIDTH=8, LANES=4, NUM_VECS=4, DEPTH=4, TIMEOUT=8.
- Reset: hold `reset`=0 for 16 cycles with random inputs -> all outputs 0 throughout and one cycle after release.
- Pass with wrap:
  - Issue a=0x01020304/b=0x10203040 and a=0xFF80_7F01/b=0x0180_0101.
  - Then issue two more vectors.
  - Return correct results at latency 2: 0x11223344 and 0x0000_8002 for the first two.
  - Expected: `finish`=1 exactly one cycle after the 4th result, `done_count`=4, `fail`=0, flags hold 20 cycles.
- Mismatch: expected 0x11223344 but `res_y`=0x11AA3344 -> `fail`=1, `fail_code`=1, `err_lanes`=4'b0100, `done_count` frozen.
- Underflow: `res_valid`=1 with no prior issue, including issue in the same cycle -> `fail_code`=2.
- Overflow and simultaneous-full:
  - 4 issues, then issue+result together -> no error, occupancy stays 4.
  - A 5th issue without result -> `fail_code`=3.
- Timeout and reset recovery:
  - 1 issue, no result for 8 cycles -> `fail_code`=4 on the next edge.
  - Assert `reset` for 1 cycle -> all outputs 0.
  - A fresh 4-vector pass run then reaches `finish`=1.
